mem_bus_arbiter: RTL and testbench

//  Shares the single-port 128x32 instruction/data Memory between two requesters.
//   - Port 0 is the MIPS CPU.
//   - Port 1 is a secondary master: program loader or debug/display reader.

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_bus_arbiter_if.sv | 49 ++++
 rtl/mem_arb_wait_ctr.sv | 23 ++
 rtl/mem_bus_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port Memory bus arbiter.
// Holds the state/owner encodings and the default bus widths.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 7;
    localparam int DATA_W_DEF = 32;
    localparam int WAIT_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OWN0 = 2'b01,
        ST_OWN1 = 2'b10
    } arb_state_t;

    typedef enum logic {
        P0 = 1'b0,
        P1 = 1'b1
    } port_id_t;

    function automatic port_id_t other_port(input port_id_t p);
        return (p == P0) ? P1 : P0;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester and Memory-side signal bundle of the arbiter.
// A requester holds req and its fields until it sees gnt; each gnt cycle is one beat.
interface mem_bus_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              r0_req;
    logic              r0_we;
    logic              r0_lock;
    logic [ADDR_W-1:0] r0_addr;
    logic [DATA_W-1:0] r0_wdata;
    logic              r0_gnt;
    logic              r0_rvalid;

    logic              r1_req;
    logic              r1_we;
    logic              r1_lock;
    logic [ADDR_W-1:0] r1_addr;
    logic [DATA_W-1:0] r1_wdata;
    logic              r1_gnt;
    logic              r1_rvalid;

    logic [DATA_W-1:0] rdata;
    logic              mem_cs;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  r0_req, r0_we, r0_lock, r0_addr, r0_wdata,
        input  r1_req, r1_we, r1_lock, r1_addr, r1_wdata,
        input  mem_rdata,
        output r0_gnt, r0_rvalid, r1_gnt, r1_rvalid,
        output rdata, mem_cs, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output r0_req, r0_we, r0_lock, r0_addr, r0_wdata,
        output r1_req, r1_we, r1_lock, r1_addr, r1_wdata,
        output mem_rdata,
        input  r0_gnt, r0_rvalid, r1_gnt, r1_rvalid,
        input  rdata, mem_cs, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arb_wait_ctr.sv
// Per-port wait counter: counts cycles spent requesting without a grant.
// Saturates instead of wrapping so a long lock cannot hide starvation.
module mem_arb_wait_ctr
    import mem_arb_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              req,
    input  logic              gnt,
    output logic [WAIT_W-1:0] cnt
);

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt <= '0;
        end else if (gnt) begin
            cnt <= '0;
        end else if (req && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the single-port Memory between the CPU (port 0) and a secondary master (port 1).
// Registered owner FSM, address/data mux and read-data capture register.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_WAIT = 4,
    parameter int CPU_PRIO = 0
) (
    input  logic       CLK,
    input  logic       RST,
    mem_bus_arbiter_if.slave bus,
    output arb_state_t dbg_state
);

    localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

    arb_state_t        state;
    arb_state_t        state_nxt;
    port_id_t          last_served;
    port_id_t          eff_last;
    port_id_t          nls;
    port_id_t          win;
    logic              gnt0;
    logic              gnt1;
    logic [WAIT_W-1:0] wait0;
    logic [WAIT_W-1:0] wait1;
    logic [WAIT_W-1:0] wait_nls;
    logic [ADDR_W-1:0] addr_mux;
    logic [DATA_W-1:0] wdata_mux;
    logic              we_mux;
    logic [DATA_W-1:0] rdata_q;
    logic              rvalid0_q;
    logic              rvalid1_q;

    assign gnt0 = (state == ST_OWN0);
    assign gnt1 = (state == ST_OWN1);

    mem_arb_wait_ctr u_wait0 (
        .CLK (CLK),
        .RST (RST),
        .req (bus.r0_req),
        .gnt (gnt0),
        .cnt (wait0)
    );

    mem_arb_wait_ctr u_wait1 (
        .CLK (CLK),
        .RST (RST),
        .req (bus.r1_req),
        .gnt (gnt1),
        .cnt (wait1)
    );

    // The beat in progress already counts as served when choosing the next owner.
    always_comb begin
        eff_last = last_served;
        if (gnt0) begin
            eff_last = P0;
        end else if (gnt1) begin
            eff_last = P1;
        end
        nls      = other_port(eff_last);
        wait_nls = (nls == P0) ? wait0 : wait1;
        if ((wait_nls >= MAX_WAIT_C) || (CPU_PRIO == 0)) begin
            win = nls;
        end else begin
            win = P0;
        end

        state_nxt = ST_IDLE;
        if (gnt0 && bus.r0_req && bus.r0_lock) begin
            state_nxt = ST_OWN0;
        end else if (gnt1 && bus.r1_req && bus.r1_lock) begin
            state_nxt = ST_OWN1;
        end else if (bus.r0_req && bus.r1_req) begin
            state_nxt = (win == P0) ? ST_OWN0 : ST_OWN1;
        end else if (bus.r0_req) begin
            state_nxt = ST_OWN0;
        end else if (bus.r1_req) begin
            state_nxt = ST_OWN1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= ST_IDLE;
            last_served <= P1;
        end else begin
            state <= state_nxt;
            if (gnt0) begin
                last_served <= P0;
            end else if (gnt1) begin
                last_served <= P1;
            end
        end
    end

    always_comb begin
        addr_mux  = '0;
        wdata_mux = '0;
        we_mux    = 1'b0;
        if (gnt0) begin
            addr_mux  = bus.r0_addr;
            wdata_mux = bus.r0_wdata;
            we_mux    = bus.r0_we;
        end else if (gnt1) begin
            addr_mux  = bus.r1_addr;
            wdata_mux = bus.r1_wdata;
            we_mux    = bus.r1_we;
        end
    end

    // Memory drives mem_rdata at the negedge of the beat; capture it at the closing posedge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rdata_q   <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            rvalid0_q <= gnt0 & ~bus.r0_we;
            rvalid1_q <= gnt1 & ~bus.r1_we;
            if ((gnt0 | gnt1) & ~we_mux) begin
                rdata_q <= bus.mem_rdata;
            end
        end
    end

    assign bus.r0_gnt    = gnt0;
    assign bus.r1_gnt    = gnt1;
    assign bus.r0_rvalid = rvalid0_q;
    assign bus.r1_rvalid = rvalid1_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_cs    = gnt0 | gnt1;
    assign bus.mem_we    = we_mux;
    assign bus.mem_addr  = addr_mux;
    assign bus.mem_wdata = wdata_mux;
    assign dbg_state     = state;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: a round-robin and a CPU-priority instance run side by side
// against a behavioural owner/wait/memory model, with directed scenarios then random traffic.
module tb_mem_bus_arbiter;
    import mem_arb_pkg::*;

    localparam int AW   = 7;
    localparam int DW   = 32;
    localparam int MAXW = 4;

    logic CLK = 1'b0;
    logic rst;
    always #5 CLK = ~CLK;

    logic          req[2][2];
    logic          wei[2][2];
    logic          lck[2][2];
    logic [AW-1:0] adr[2][2];
    logic [DW-1:0] wdt[2][2];
    logic          gnt[2][2];
    logic          rvl[2][2];
    logic [DW-1:0] rdt[2];
    logic          cs[2];
    logic          mwe[2];
    logic [AW-1:0] madr[2];
    logic [DW-1:0] mwd[2];
    logic [DW-1:0] mrd[2];
    arb_state_t    dbg[2];

    mem_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus[2] ();

    for (genvar d = 0; d < 2; d++) begin : g_dut
        assign bus[d].r0_req    = req[d][0];
        assign bus[d].r0_we     = wei[d][0];
        assign bus[d].r0_lock   = lck[d][0];
        assign bus[d].r0_addr   = adr[d][0];
        assign bus[d].r0_wdata  = wdt[d][0];
        assign bus[d].r1_req    = req[d][1];
        assign bus[d].r1_we     = wei[d][1];
        assign bus[d].r1_lock   = lck[d][1];
        assign bus[d].r1_addr   = adr[d][1];
        assign bus[d].r1_wdata  = wdt[d][1];
        assign bus[d].mem_rdata = mrd[d];
        assign gnt[d][0] = bus[d].r0_gnt;
        assign gnt[d][1] = bus[d].r1_gnt;
        assign rvl[d][0] = bus[d].r0_rvalid;
        assign rvl[d][1] = bus[d].r1_rvalid;
        assign rdt[d]    = bus[d].rdata;
        assign cs[d]     = bus[d].mem_cs;
        assign mwe[d]    = bus[d].mem_we;
        assign madr[d]   = bus[d].mem_addr;
        assign mwd[d]    = bus[d].mem_wdata;

        mem_bus_arbiter #(
            .ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MAXW), .CPU_PRIO(d)
        ) u_dut (
            .CLK       (CLK),
            .RST       (rst),
            .bus       (bus[d]),
            .dbg_state (dbg[d])
        );
    end

    function automatic logic [DW-1:0] init_word(input int a);
        if (a == 5) return 32'hDEADBEEF;
        return 32'(32'h9E3779B9 * (a + 1));
    endfunction

    // Bench-side RAM: samples the DUT's Memory strobes on the negedge.
    logic [DW-1:0] ram[2][128];
    bit ram_ready = 1'b0;
    always @(negedge CLK) begin
        if (!ram_ready) begin
            for (int d = 0; d < 2; d++)
                for (int a = 0; a < 128; a++) ram[d][a] <= init_word(a);
            ram_ready <= 1'b1;
        end
        for (int d = 0; d < 2; d++) begin
            if (cs[d] && mwe[d]) ram[d][madr[d]] <= mwd[d];
            if (cs[d] && !mwe[d]) mrd[d] <= ram[d][madr[d]];
            else                  mrd[d] <= $urandom;
        end
    end

    // Model: owner of the current cycle (0 idle, 1 port0, 2 port1), waits, last served, read pipe.
    int            m_own[2];
    int            m_wait[2][2];
    int            m_last[2];
    bit            m_rv[2][2];
    logic [DW-1:0] m_rdata[2];
    logic [DW-1:0] ref_mem[2][128];
    int            prev_own[2];
    int            gq[2][$];
    int            total = 0;
    int            bad   = 0;
    int            exp_rr[4] = '{0, 1, 0, 1};
    int            exp_pr[5] = '{0, 0, 0, 0, 1};
    int            exp_lk[4] = '{0, 0, 0, 1};

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst=%0d t=%0t actual=%h required=%h", nm, d, $time, act, exp);
        end
    endtask

    task automatic model_step(input int d);
        int o;
        int el;
        int nls;
        int nxt;
        o = m_own[d];
        if (o != 0 && wei[d][o-1]) ref_mem[d][adr[d][o-1]] = wdt[d][o-1];
        if (rst) begin
            m_own[d]   = 0;
            m_last[d]  = 1;
            m_rdata[d] = '0;
            for (int p = 0; p < 2; p++) begin
                m_wait[d][p] = 0;
                m_rv[d][p]   = 1'b0;
            end
        end else begin
            for (int p = 0; p < 2; p++) m_rv[d][p] = (o == p + 1) && !wei[d][p];
            if (o != 0 && !wei[d][o-1]) m_rdata[d] = ref_mem[d][adr[d][o-1]];
            el  = (o != 0) ? o - 1 : m_last[d];
            nls = 1 - el;
            if (o != 0 && req[d][o-1] && lck[d][o-1])  nxt = o;
            else if (req[d][0] && req[d][1])           nxt = (m_wait[d][nls] >= MAXW || d == 0) ? nls + 1 : 1;
            else if (req[d][0])                        nxt = 1;
            else if (req[d][1])                        nxt = 2;
            else                                       nxt = 0;
            for (int p = 0; p < 2; p++) begin
                if (o == p + 1)                          m_wait[d][p] = 0;
                else if (req[d][p] && m_wait[d][p] < 15) m_wait[d][p] = m_wait[d][p] + 1;
            end
            m_last[d] = el;
            m_own[d]  = nxt;
        end
    endtask

    task automatic compare(input int d);
        int o;
        arb_state_t es;
        o  = m_own[d];
        es = (o == 0) ? ST_IDLE : (o == 1) ? ST_OWN0 : ST_OWN1;
        chk("gnt0",   d, 32'(gnt[d][0]), 32'(o == 1));
        chk("gnt1",   d, 32'(gnt[d][1]), 32'(o == 2));
        chk("mem_cs", d, 32'(cs[d]),     32'(o != 0));
        chk("mem_we", d, 32'(mwe[d]),    (o != 0) ? 32'(wei[d][o-1]) : 32'd0);
        chk("mem_addr",  d, 32'(madr[d]), (o != 0) ? 32'(adr[d][o-1]) : 32'd0);
        chk("mem_wdata", d, mwd[d],       (o != 0) ? wdt[d][o-1] : 32'd0);
        chk("rvalid0", d, 32'(rvl[d][0]), 32'(m_rv[d][0]));
        chk("rvalid1", d, 32'(rvl[d][1]), 32'(m_rv[d][1]));
        chk("rdata",   d, rdt[d], m_rdata[d]);
        chk("state",   d, 32'(dbg[d]), 32'(es));
    endtask

    task automatic tick();
        #1;
        for (int d = 0; d < 2; d++) compare(d);
        @(posedge CLK);
        #1;
        for (int d = 0; d < 2; d++) begin
            prev_own[d] = m_own[d];
            model_step(d);
            gq[d].push_back(gnt[d][0] ? 0 : (gnt[d][1] ? 1 : -1));
        end
    endtask

    task automatic set_p(input int p, input logic r, input logic w, input logic l,
                         input logic [AW-1:0] a, input logic [DW-1:0] wd);
        for (int d = 0; d < 2; d++) begin
            req[d][p] = r;
            wei[d][p] = w;
            lck[d][p] = l;
            adr[d][p] = a;
            wdt[d][p] = wd;
        end
    endtask

    task automatic clear_all();
        set_p(0, 1'b0, 1'b0, 1'b0, 7'd0, 32'd0);
        set_p(1, 1'b0, 1'b0, 1'b0, 7'd0, 32'd0);
    endtask

    task automatic do_reset();
        clear_all();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int d = 0; d < 2; d++) gq[d].delete();
    endtask

    task automatic drive_random();
        rst = ($urandom_range(0, 199) == 0);
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++)
                if (!req[d][p] || prev_own[d] == p + 1) begin
                    req[d][p] = ($urandom_range(0, 99) < 60);
                    wei[d][p] = 1'($urandom_range(0, 1));
                    lck[d][p] = ($urandom_range(0, 3) == 0);
                    adr[d][p] = AW'($urandom_range(0, 127));
                    wdt[d][p] = $urandom;
                end
    endtask

    initial begin
        rst = 1'b1;
        clear_all();
        for (int d = 0; d < 2; d++) begin
            m_own[d]    = 0;
            prev_own[d] = 0;
            for (int a = 0; a < 128; a++) ref_mem[d][a] = init_word(a);
        end
        @(posedge CLK);
        #1;
        for (int d = 0; d < 2; d++) model_step(d);
        do_reset();

        for (int d = 0; d < 2; d++) begin
            chk("rst_gnt0",    d, 32'(gnt[d][0]), 32'd0);
            chk("rst_gnt1",    d, 32'(gnt[d][1]), 32'd0);
            chk("rst_rvalid1", d, 32'(rvl[d][1]), 32'd0);
            chk("rst_mem_cs",  d, 32'(cs[d]),     32'd0);
            chk("rst_rdata",   d, rdt[d],         32'd0);
        end

        // Single read of the preloaded word.
        set_p(0, 1'b1, 1'b0, 1'b0, 7'd5, 32'd0);
        tick();
        chk("t1_gnt0", 0, 32'(gnt[0][0]), 32'd1);
        set_p(0, 1'b0, 1'b0, 1'b0, 7'd5, 32'd0);
        tick();
        chk("t1_rvalid0", 0, 32'(rvl[0][0]), 32'd1);
        chk("t1_rdata",   0, rdt[0], 32'hDEADBEEF);

        // Port 1 write then read back.
        set_p(1, 1'b1, 1'b1, 1'b0, 7'd9, 32'h12345678);
        tick();
        chk("t2_gnt1",   1, 32'(gnt[1][1]), 32'd1);
        chk("t2_mem_we", 1, 32'(mwe[1]),    32'd1);
        set_p(1, 1'b0, 1'b1, 1'b0, 7'd9, 32'h12345678);
        tick();
        set_p(1, 1'b1, 1'b0, 1'b0, 7'd9, 32'd0);
        tick();
        set_p(1, 1'b0, 1'b0, 1'b0, 7'd9, 32'd0);
        tick();
        chk("t2_rvalid1", 1, 32'(rvl[1][1]), 32'd1);
        chk("t2_rdata",   1, rdt[1], 32'h12345678);
        tick();

        // Reset during the grant cycle of a port 1 read.
        set_p(1, 1'b1, 1'b0, 1'b0, 7'd20, 32'd0);
        tick();
        chk("t6_gnt1", 1, 32'(gnt[1][1]), 32'd1);
        set_p(1, 1'b0, 1'b0, 1'b0, 7'd20, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk("t6_rvalid1", d, 32'(rvl[d][1]), 32'd0);
            chk("t6_gnt1_low", d, 32'(gnt[d][1]), 32'd0);
            chk("t6_mem_cs", d, 32'(cs[d]), 32'd0);
            chk("t6_rdata",  d, rdt[d], 32'd0);
        end
        tick();

        // Continuous contention: round-robin and starvation-bounded priority.
        do_reset();
        set_p(0, 1'b1, 1'b0, 1'b0, 7'd1, 32'd0);
        set_p(1, 1'b1, 1'b0, 1'b0, 7'd2, 32'd0);
        repeat (12) tick();
        for (int i = 0; i < 4; i++) chk("t3_rr_seq",   0, 32'(gq[0][i]), 32'(exp_rr[i]));
        for (int i = 0; i < 5; i++) chk("t4_prio_seq", 1, 32'(gq[1][i]), 32'(exp_pr[i]));

        // Locked three-beat sequence on port 0 while port 1 waits.
        do_reset();
        set_p(0, 1'b1, 1'b0, 1'b1, 7'd3, 32'd0);
        set_p(1, 1'b1, 1'b0, 1'b0, 7'd4, 32'd0);
        repeat (3) tick();
        set_p(0, 1'b0, 1'b0, 1'b0, 7'd3, 32'd0);
        repeat (2) tick();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 4; i++) chk("t5_lock_seq", d, 32'(gq[d][i]), 32'(exp_lk[i]));

        // Long lock: port 1 wait count must saturate rather than wrap.
        do_reset();
        set_p(1, 1'b1, 1'b0, 1'b0, 7'd6, 32'd0);
        for (int c = 0; c < 17; c++) begin
            set_p(0, 1'b1, 1'b0, (c < 16), 7'd7, 32'd0);
            tick();
        end
        for (int d = 0; d < 2; d++) chk("t7_sat_gnt1", d, 32'(gnt[d][1]), 32'd1);

        do_reset();
        repeat (3000) begin
            drive_random();
            tick();
        end
        rst = 1'b0;
        clear_all();
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
